// File: rtl/rca_pr_scheduler_pkg.sv
// Shared configuration for the partial-reconfiguration scheduler:
// grid/OU sizing, derived field widths and the request record.
package rca_config;

    localparam int MAX_PR_QUEUE_REQUESTS = 8;
    localparam int NUM_GRID_MUXES        = 30;
    localparam int NUM_OUS               = 22;

    localparam int PR_SLOT_W = $clog2(NUM_GRID_MUXES);
    localparam int OU_ID_W   = $clog2(NUM_OUS);

    typedef struct packed {
        logic [PR_SLOT_W-1:0] slot;
        logic [OU_ID_W-1:0]   ou;
    } pr_request_t;

endpackage

// File: rtl/rca_pr_scheduler_queue.sv
// Compacting FIFO of PR requests; head at entry 0, per-entry valid bits
// and a parallel slot comparator so a repeat request can coalesce in place.
module rca_pr_queue
    import rca_config::*;
#(
    parameter int DEPTH     = MAX_PR_QUEUE_REQUESTS,
    parameter int NUM_SLOTS = NUM_GRID_MUXES,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    input  pr_request_t          req_i,
    output logic                 hit_o,
    output pr_request_t          head_o,
    output logic [CNT_W-1:0]     count_o,
    output logic [NUM_SLOTS-1:0] slot_mask_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pr_request_t          ent_q [DEPTH];
    pr_request_t          ent_d [DEPTH];
    logic [DEPTH-1:0]     vld_q, vld_d;
    logic [DEPTH-1:0]     match;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // The head leaving this cycle must not absorb a new request.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = vld_q[i] && (ent_q[i].slot == req_i.slot) &&
                       !(pop_i && i == 0);
        end
    end

    assign hit_o = |match;

    always_comb begin
        ent_d = ent_q;
        vld_d = vld_q;
        cnt_d = cnt_q;
        if (pop_i) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_d[i] = ent_q[i+1];
                vld_d[i] = vld_q[i+1];
            end
            ent_d[DEPTH-1] = '0;
            vld_d[DEPTH-1] = 1'b0;
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (push_i) begin
            if (hit_o) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (match[i] && !pop_i) ent_d[i].ou = req_i.ou;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (match[i] && pop_i) ent_d[i-1].ou = req_i.ou;
                end
            end else begin
                ent_d[cnt_d[IDX_W-1:0]] = req_i;
                vld_d[cnt_d[IDX_W-1:0]] = 1'b1;
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
        if (flush_i) begin
            vld_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        slot_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && int'(ent_q[i].slot) < NUM_SLOTS)
                slot_mask_o[ent_q[i].slot] = 1'b1;
        end
    end

    assign head_o  = ent_q[0];
    assign count_o = cnt_q;

endmodule

// File: rtl/rca_pr_scheduler.sv
// PR scheduler: queues slot reconfiguration requests and issues them one
// at a time to the PR controller, tracking which grid slots are busy.
module rca_pr_scheduler
    import rca_config::*;
#(
    parameter int DEPTH     = MAX_PR_QUEUE_REQUESTS,
    parameter int NUM_SLOTS = NUM_GRID_MUXES,
    parameter int NUM_OU    = NUM_OUS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [PR_SLOT_W-1:0]         req_slot,
    input  logic [OU_ID_W-1:0]           req_ou,
    input  logic                         flush,
    output logic                         pr_start,
    output logic [PR_SLOT_W-1:0]         pr_slot,
    output logic [OU_ID_W-1:0]           pr_ou,
    input  logic                         pr_done,
    output logic [NUM_SLOTS-1:0]         slot_busy,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } pr_sched_state_t;

    pr_sched_state_t      state_q;
    logic                 pr_start_q;
    logic                 inflight_q;
    logic [PR_SLOT_W-1:0] pr_slot_q;
    logic [OU_ID_W-1:0]   pr_ou_q;

    logic                 oor;
    logic                 push;
    logic                 pop;
    logic                 q_hit;
    logic [CNT_W-1:0]     q_cnt;
    logic [NUM_SLOTS-1:0] q_mask;
    pr_request_t          q_head;
    pr_request_t          q_req;

    // Out-of-range requests are swallowed so a bad client cannot stall.
    assign oor = (int'(req_slot) >= NUM_SLOTS) || (int'(req_ou) >= NUM_OU);

    assign req_ready = !flush && (oor || q_cnt < CNT_W'(DEPTH) || q_hit);
    assign push      = req_valid && req_ready && !oor;
    assign pop       = (state_q == IDLE) && (q_cnt != '0) && !flush;

    assign q_req.slot = req_slot;
    assign q_req.ou   = req_ou;

    rca_pr_queue #(
        .DEPTH     (DEPTH),
        .NUM_SLOTS (NUM_SLOTS),
        .CNT_W     (CNT_W)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (flush),
        .req_i       (q_req),
        .hit_o       (q_hit),
        .head_o      (q_head),
        .count_o     (q_cnt),
        .slot_mask_o (q_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pr_start_q <= 1'b0;
            inflight_q <= 1'b0;
            pr_slot_q  <= '0;
            pr_ou_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        pr_slot_q  <= q_head.slot;
                        pr_ou_q    <= q_head.ou;
                        inflight_q <= 1'b1;
                        pr_start_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    pr_start_q <= 1'b0;
                    state_q    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (pr_done) begin
                        inflight_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    pr_start_q <= 1'b0;
                    inflight_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        slot_busy = q_mask;
        if (inflight_q && int'(pr_slot_q) < NUM_SLOTS)
            slot_busy[pr_slot_q] = 1'b1;
    end

    assign pr_start    = pr_start_q;
    assign pr_slot     = pr_slot_q;
    assign pr_ou       = pr_ou_q;
    assign queue_count = q_cnt;

endmodule

// File: tb/tb_rca_pr_scheduler.sv
// Directed bench for rca_pr_scheduler: a vector table for the basic
// issue/coalesce/drop flow plus hand sequences for full, flush and reset.
module tb_rca_pr_scheduler;
    import rca_config::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [PR_SLOT_W-1:0] req_slot;
    logic [OU_ID_W-1:0]   req_ou;
    logic                 flush;
    logic                 pr_start;
    logic [PR_SLOT_W-1:0] pr_slot;
    logic [OU_ID_W-1:0]   pr_ou;
    logic                 pr_done;
    logic [29:0]          slot_busy;
    logic [3:0]           queue_count;

    int n_chk = 0;
    int n_fail = 0;

    rca_pr_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_slot    (req_slot),
        .req_ou      (req_ou),
        .flush       (flush),
        .pr_start    (pr_start),
        .pr_slot     (pr_slot),
        .pr_ou       (pr_ou),
        .pr_done     (pr_done),
        .slot_busy   (slot_busy),
        .queue_count (queue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  slot;
        logic [4:0]  ou;
        logic        fl;
        logic        dn;
        logic        rdy;
        logic        st;
        logic [4:0]  ps;
        logic [4:0]  po;
        logic [3:0]  cnt;
        logic [29:0] busy;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [29:0] b(input int i);
        return 30'(1) << i;
    endfunction

    function automatic vec_t mk(input logic v, input int sl, input int ou,
                                input logic fl, input logic dn,
                                input logic rdy, input logic st,
                                input int ps, input int po, input int cnt,
                                input logic [29:0] busy);
        vec_t r;
        r.v = v; r.slot = 5'(sl); r.ou = 5'(ou);
        r.fl = fl; r.dn = dn; r.rdy = rdy; r.st = st;
        r.ps = 5'(ps); r.po = 5'(po); r.cnt = 4'(cnt); r.busy = busy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int sl, input int ou,
                         input logic fl, input logic dn);
        req_valid = v;
        req_slot  = 5'(sl);
        req_ou    = 5'(ou);
        flush     = fl;
        pr_done   = dn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill_inflight_and_wait();
        drive(1'b1, 0, 1, 1'b0, 1'b0);
        step();
        step();
        chk("first_start", 64'(pr_start), 64'd1);
        step();
    endtask

    initial begin
        tbl[0]  = mk(1, 3, 7,  0, 0, 1, 0, 0,  0, 1, b(3));
        tbl[1]  = mk(0, 0, 0,  0, 0, 1, 1, 3,  7, 0, b(3));
        tbl[2]  = mk(0, 0, 0,  0, 0, 1, 0, 0,  0, 0, b(3));
        tbl[3]  = mk(0, 0, 0,  0, 1, 1, 0, 0,  0, 0, 30'd0);
        tbl[4]  = mk(1, 10, 2, 0, 0, 1, 0, 0,  0, 1, b(10));
        tbl[5]  = mk(1, 4, 1,  0, 0, 1, 1, 10, 2, 1, b(10) | b(4));
        tbl[6]  = mk(1, 4, 9,  0, 0, 1, 0, 0,  0, 1, b(10) | b(4));
        tbl[7]  = mk(1, 31, 5, 0, 0, 1, 0, 0,  0, 1, b(10) | b(4));
        tbl[8]  = mk(1, 5, 30, 0, 0, 1, 0, 0,  0, 1, b(10) | b(4));
        tbl[9]  = mk(0, 0, 0,  0, 1, 1, 0, 0,  0, 1, b(4));
        tbl[10] = mk(0, 0, 0,  0, 0, 1, 1, 4,  9, 0, b(4));
        tbl[11] = mk(0, 0, 0,  0, 0, 1, 0, 0,  0, 0, b(4));
        tbl[12] = mk(0, 0, 0,  0, 1, 1, 0, 0,  0, 0, 30'd0);
        tbl[13] = mk(0, 0, 0,  0, 0, 1, 0, 0,  0, 0, 30'd0);
        tbl[14] = mk(0, 0, 0,  0, 1, 1, 0, 0,  0, 0, 30'd0);
        tbl[15] = mk(1, 6, 2,  1, 0, 0, 0, 0,  0, 0, 30'd0);

        // Reset state
        do_reset();
        chk("rst_start", 64'(pr_start), 64'd0);
        chk("rst_count", 64'(queue_count), 64'd0);
        chk("rst_busy", 64'(slot_busy), 64'd0);
        chk("rst_slot", 64'(pr_slot), 64'd0);
        chk("rst_ou", 64'(pr_ou), 64'd0);

        for (int k = 0; k < 16; k++) begin
            drive(tbl[k].v, int'(tbl[k].slot), int'(tbl[k].ou),
                  tbl[k].fl, tbl[k].dn);
            #1;
            chk($sformatf("v%0d_ready", k), 64'(req_ready), 64'(tbl[k].rdy));
            step();
            chk($sformatf("v%0d_start", k), 64'(pr_start), 64'(tbl[k].st));
            chk($sformatf("v%0d_count", k), 64'(queue_count),
                64'(tbl[k].cnt));
            chk($sformatf("v%0d_busy", k), 64'(slot_busy), 64'(tbl[k].busy));
            if (tbl[k].st) begin
                chk($sformatf("v%0d_slot", k), 64'(pr_slot), 64'(tbl[k].ps));
                chk($sformatf("v%0d_ou", k), 64'(pr_ou), 64'(tbl[k].po));
            end
        end

        // Full queue: only coalescing pushes accepted, no pass-through on pop
        do_reset();
        fill_inflight_and_wait();
        for (int s = 1; s <= 8; s++) begin
            drive(1'b1, s, s + 1, 1'b0, 1'b0);
            step();
        end
        chk("full_count", 64'(queue_count), 64'd8);
        drive(1'b1, 20, 0, 1'b0, 1'b0);
        #1;
        chk("full_new_ready", 64'(req_ready), 64'd0);
        drive(1'b1, 5, 11, 1'b0, 1'b0);
        #1;
        chk("full_hit_ready", 64'(req_ready), 64'd1);
        step();
        chk("full_hit_count", 64'(queue_count), 64'd8);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        step();
        drive(1'b1, 20, 0, 1'b0, 1'b0);
        #1;
        chk("full_pop_ready", 64'(req_ready), 64'd0);
        step();
        chk("drain1_start", 64'(pr_start), 64'd1);
        chk("drain1_slot", 64'(pr_slot), 64'd1);
        chk("drain1_ou", 64'(pr_ou), 64'd2);
        chk("drain1_count", 64'(queue_count), 64'd7);
        for (int s = 2; s <= 8; s++) begin
            step();
            drive(1'b0, 0, 0, 1'b0, 1'b1);
            step();
            step();
            chk($sformatf("drain%0d_start", s), 64'(pr_start), 64'd1);
            chk($sformatf("drain%0d_slot", s), 64'(pr_slot), 64'(s));
            chk($sformatf("drain%0d_ou", s), 64'(pr_ou),
                64'((s == 5) ? 11 : s + 1));
        end
        step();
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        step();
        step();
        chk("drain_end_start", 64'(pr_start), 64'd0);
        chk("drain_end_count", 64'(queue_count), 64'd0);
        chk("drain_end_busy", 64'(slot_busy), 64'd0);

        // Flush with requests queued behind an in-flight one
        do_reset();
        fill_inflight_and_wait();
        for (int s = 1; s <= 5; s++) begin
            drive(1'b1, s, 2, 1'b0, 1'b0);
            step();
        end
        chk("fl_count_pre", 64'(queue_count), 64'd5);
        drive(1'b0, 0, 0, 1'b1, 1'b0);
        step();
        chk("fl_count", 64'(queue_count), 64'd0);
        chk("fl_busy", 64'(slot_busy), 64'(b(0)));
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        step();
        chk("fl_done_busy", 64'(slot_busy), 64'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("fl_idle%0d_start", c), 64'(pr_start), 64'd0);
        end

        // Asynchronous reset in WAIT_DONE
        do_reset();
        drive(1'b1, 7, 3, 1'b0, 1'b0);
        step();
        step();
        chk("ar_start", 64'(pr_start), 64'd1);
        drive(1'b1, 8, 4, 1'b0, 1'b0);
        step();
        chk("ar_busy_pre", 64'(slot_busy), 64'(b(7) | b(8)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_start0", 64'(pr_start), 64'd0);
        chk("ar_slot0", 64'(pr_slot), 64'd0);
        chk("ar_ou0", 64'(pr_ou), 64'd0);
        chk("ar_busy0", 64'(slot_busy), 64'd0);
        chk("ar_count0", 64'(queue_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        step();
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("ar_late%0d_start", c), 64'(pr_start), 64'd0);
        end
        chk("ar_late_busy", 64'(slot_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
